// File: rtl/flex_counter_if.sv
// Control/status bundle for flex_counter_ext: master drives controls, slave is the counter.
interface flex_counter_if #(
  parameter int NUM_CNT_BITS  = 8,
  parameter int PRESCALE_BITS = 4
);
  logic                     clear;
  logic                     load;
  logic [NUM_CNT_BITS-1:0]  load_val;
  logic                     count_enable;
  logic                     count_down;
  logic                     saturate;
  logic [NUM_CNT_BITS-1:0]  rollover_val;
  logic [PRESCALE_BITS-1:0] prescale_val;
  logic [NUM_CNT_BITS-1:0]  count_out;
  logic                     rollover_flag;
  logic                     zero_flag;
  logic                     wrap_pulse;

  modport master (
    output clear, load, load_val, count_enable, count_down, saturate,
           rollover_val, prescale_val,
    input  count_out, rollover_flag, zero_flag, wrap_pulse
  );

  modport slave (
    input  clear, load, load_val, count_enable, count_down, saturate,
           rollover_val, prescale_val,
    output count_out, rollover_flag, zero_flag, wrap_pulse
  );
endinterface

// File: rtl/flex_counter_ext.sv
// Prescaled up/down counter with wrap or saturate at 0 / rollover_val, plus registered flags.
module flex_counter_ext #(
  parameter int NUM_CNT_BITS  = 8,
  parameter int PRESCALE_BITS = 4
) (
  input  logic          clk,
  input  logic          rst,
  flex_counter_if.slave bus
);
  logic [NUM_CNT_BITS-1:0]  count, next_cnt;
  logic [PRESCALE_BITS-1:0] pre_cnt, next_pre;
  logic                     step, next_wrap;
  logic                     rollover_flag, zero_flag, wrap_pulse;

  always_comb begin
    next_cnt  = count;
    next_pre  = pre_cnt;
    next_wrap = 1'b0;
    step      = 1'b0;
    if (bus.clear) begin
      next_cnt = '0;
      next_pre = '0;
    end else if (bus.load) begin
      next_cnt = bus.load_val;
      next_pre = '0;
    end else if (bus.count_enable) begin
      if (pre_cnt >= bus.prescale_val) begin
        next_pre = '0;
        step     = 1'b1;
      end else begin
        next_pre = pre_cnt + 1'b1;
      end
    end

    // Using >= on the up side keeps count+1 from ever overflowing, even after a load above the limit.
    if (step) begin
      if (!bus.count_down) begin
        if (count < bus.rollover_val) begin
          next_cnt = count + 1'b1;
        end else if (!bus.saturate) begin
          next_cnt  = '0;
          next_wrap = 1'b1;
        end
      end else begin
        if (count != '0) begin
          next_cnt = count - 1'b1;
        end else if (!bus.saturate) begin
          next_cnt  = bus.rollover_val;
          next_wrap = 1'b1;
        end
      end
    end
  end

  // Flags are derived from next_cnt so they land in the same cycle as the count they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count         <= '0;
      pre_cnt       <= '0;
      rollover_flag <= 1'b0;
      zero_flag     <= 1'b0;
      wrap_pulse    <= 1'b0;
    end else begin
      count         <= next_cnt;
      pre_cnt       <= next_pre;
      rollover_flag <= (next_cnt == bus.rollover_val);
      zero_flag     <= (next_cnt == '0);
      wrap_pulse    <= next_wrap;
    end
  end

  assign bus.count_out     = count;
  assign bus.rollover_flag = rollover_flag;
  assign bus.zero_flag     = zero_flag;
  assign bus.wrap_pulse    = wrap_pulse;
endmodule

// File: tb/tb_flex_counter_ext.sv
// Directed bench for flex_counter_ext; observed word is {count_out, rollover_flag, zero_flag, wrap_pulse}.
module tb_flex_counter_ext;
  localparam int W = 8;
  localparam int P = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  flex_counter_if #(.NUM_CNT_BITS(W), .PRESCALE_BITS(P)) bus ();

  flex_counter_ext #(.NUM_CNT_BITS(W), .PRESCALE_BITS(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input logic dn, input logic sat, input logic [W-1:0] rv,
                          input logic [P-1:0] pv);
    bus.count_down   = dn;
    bus.saturate     = sat;
    bus.rollover_val = rv;
    bus.prescale_val = pv;
  endtask

  task automatic test_reset();
    logic [W+2:0] obs;
    bus.clear = 0; bus.load = 0; bus.load_val = '0; bus.count_enable = 0;
    set_mode(0, 0, 8'd5, 4'd0);
    rst = 1'b1;
    #1;
    obs = {bus.count_out, bus.rollover_flag, bus.zero_flag, bus.wrap_pulse};
    total++;
    if (obs !== 11'd0) begin bad++; $display("FAIL reset_initial: got %h want %h", obs, 11'd0); end
    tick();
    obs = {bus.count_out, bus.rollover_flag, bus.zero_flag, bus.wrap_pulse};
    total++;
    if (obs !== 11'd0) begin bad++; $display("FAIL reset_edge: got %h want %h", obs, 11'd0); end
    rst = 1'b0;
    tick();
    obs = {bus.count_out, bus.rollover_flag, bus.zero_flag, bus.wrap_pulse};
    total++;
    if (obs !== {8'd0, 1'b0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL reset_first_edge: got %h want %h", obs, {8'd0, 1'b0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_up_wrap();
    logic [W-1:0] ec [7] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1};
    logic [W+2:0] obs, exp;
    bus.clear = 1; tick(); bus.clear = 0;
    set_mode(0, 0, 8'd5, 4'd0);
    bus.count_enable = 1;
    for (int i = 0; i < 7; i++) begin
      tick();
      obs = {bus.count_out, bus.rollover_flag, bus.zero_flag, bus.wrap_pulse};
      exp = {ec[i], ec[i] == 8'd5, ec[i] == 8'd0, i == 5};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL up_wrap[%0d]: got %h want %h", i, obs, exp); end
    end
    bus.count_enable = 0;
  endtask

  task automatic test_prescale();
    logic         en [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] ec [8] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2};
    logic [W+2:0] obs, exp;
    bus.clear = 1; tick(); bus.clear = 0;
    set_mode(0, 0, 8'd3, 4'd2);
    for (int i = 0; i < 8; i++) begin
      bus.count_enable = en[i];
      tick();
      obs = {bus.count_out, bus.rollover_flag, bus.zero_flag, bus.wrap_pulse};
      exp = {ec[i], 1'b0, ec[i] == 8'd0, 1'b0};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL prescale[%0d]: got %h want %h", i, obs, exp); end
    end
    bus.count_enable = 0;
  endtask

  task automatic test_down();
    logic [W-1:0] ec [5] = '{8'd2, 8'd1, 8'd0, 8'd9, 8'd8};
    logic [W+2:0] obs, exp;
    set_mode(0, 0, 8'd9, 4'd0);
    bus.load = 1; bus.load_val = 8'd2; bus.count_enable = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.load = 0;
      bus.count_down = 1;
      obs = {bus.count_out, bus.rollover_flag, bus.zero_flag, bus.wrap_pulse};
      exp = {ec[i], ec[i] == 8'd9, ec[i] == 8'd0, i == 3};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL down[%0d]: got %h want %h", i, obs, exp); end
    end
    bus.count_enable = 0;
  endtask

  task automatic test_saturate();
    logic [W-1:0] eu [4] = '{8'd6, 8'd7, 8'd7, 8'd7};
    logic [W-1:0] ed [3] = '{8'd1, 8'd0, 8'd0};
    logic [W+2:0] obs, exp;
    set_mode(0, 1, 8'd7, 4'd0);
    bus.load = 1; bus.load_val = 8'd6; bus.count_enable = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.load = 0;
      obs = {bus.count_out, bus.rollover_flag, bus.zero_flag, bus.wrap_pulse};
      exp = {eu[i], eu[i] == 8'd7, 1'b0, 1'b0};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL sat_up[%0d]: got %h want %h", i, obs, exp); end
    end
    bus.count_down = 1;
    bus.load = 1; bus.load_val = 8'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.load = 0;
      obs = {bus.count_out, bus.rollover_flag, bus.zero_flag, bus.wrap_pulse};
      exp = {ed[i], 1'b0, ed[i] == 8'd0, 1'b0};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL sat_down[%0d]: got %h want %h", i, obs, exp); end
    end
    bus.count_enable = 0;
  endtask

  task automatic test_priority();
    logic [W+2:0] obs, exp;
    set_mode(0, 0, 8'd10, 4'd0);
    bus.load = 1; bus.load_val = 8'd3; tick();
    bus.clear = 1; bus.load_val = 8'd50; bus.count_enable = 1;
    tick();
    bus.clear = 0;
    obs = {bus.count_out, bus.rollover_flag, bus.zero_flag, bus.wrap_pulse};
    exp = {8'd0, 1'b0, 1'b1, 1'b0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL clear_over_load: got %h want %h", obs, exp); end
    bus.load_val = 8'd200;
    tick();
    bus.load = 0;
    obs = {bus.count_out, bus.rollover_flag, bus.zero_flag, bus.wrap_pulse};
    exp = {8'd200, 1'b0, 1'b0, 1'b0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL load_above_rv: got %h want %h", obs, exp); end
    tick();
    obs = {bus.count_out, bus.rollover_flag, bus.zero_flag, bus.wrap_pulse};
    exp = {8'd0, 1'b0, 1'b1, 1'b1};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL above_rv_wrap: got %h want %h", obs, exp); end
    bus.count_enable = 0;
  endtask

  task automatic test_rv_zero();
    logic [W+2:0] obs, exp;
    set_mode(0, 0, 8'd0, 4'd0);
    bus.clear = 1; tick(); bus.clear = 0;
    bus.count_enable = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      obs = {bus.count_out, bus.rollover_flag, bus.zero_flag, bus.wrap_pulse};
      exp = {8'd0, 1'b1, 1'b1, 1'b1};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL rv_zero[%0d]: got %h want %h", i, obs, exp); end
    end
    // Holding: the rollover flag must still follow rollover_val changes.
    bus.count_enable = 0;
    bus.rollover_val = 8'd4;
    tick();
    obs = {bus.count_out, bus.rollover_flag, bus.zero_flag, bus.wrap_pulse};
    exp = {8'd0, 1'b0, 1'b1, 1'b0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL rv_change_hold_a: got %h want %h", obs, exp); end
    bus.rollover_val = 8'd0;
    tick();
    obs = {bus.count_out, bus.rollover_flag, bus.zero_flag, bus.wrap_pulse};
    exp = {8'd0, 1'b1, 1'b1, 1'b0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL rv_change_hold_b: got %h want %h", obs, exp); end
  endtask

  task automatic test_all_ones();
    logic [W-1:0] ec [3] = '{8'd254, 8'd255, 8'd0};
    logic [W+2:0] obs, exp;
    set_mode(0, 0, 8'd255, 4'd0);
    bus.load = 1; bus.load_val = 8'd254; bus.count_enable = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.load = 0;
      obs = {bus.count_out, bus.rollover_flag, bus.zero_flag, bus.wrap_pulse};
      exp = {ec[i], ec[i] == 8'd255, ec[i] == 8'd0, i == 2};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL all_ones[%0d]: got %h want %h", i, obs, exp); end
    end
    bus.count_enable = 0;
  endtask

  task automatic test_mode_change();
    logic         dn [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] ec [5] = '{8'd5, 8'd6, 8'd5, 8'd4, 8'd5};
    logic [W+2:0] obs, exp;
    set_mode(0, 0, 8'd9, 4'd0);
    bus.load = 1; bus.load_val = 8'd5; bus.count_enable = 1;
    for (int i = 0; i < 5; i++) begin
      bus.count_down = dn[i];
      tick();
      bus.load = 0;
      obs = {bus.count_out, bus.rollover_flag, bus.zero_flag, bus.wrap_pulse};
      exp = {ec[i], 1'b0, 1'b0, 1'b0};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL mode_change[%0d]: got %h want %h", i, obs, exp); end
    end
    bus.count_enable = 0;
  endtask

  task automatic test_async_reset();
    logic [W-1:0] ec [4] = '{8'd0, 8'd0, 8'd1, 8'd1};
    logic [W+2:0] obs, exp;
    set_mode(0, 0, 8'd9, 4'd2);
    bus.clear = 1; tick(); bus.clear = 0;
    bus.count_enable = 1;
    for (int i = 0; i < 13; i++) tick();
    obs = {bus.count_out, bus.rollover_flag, bus.zero_flag, bus.wrap_pulse};
    exp = {8'd4, 1'b0, 1'b0, 1'b0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL pre_reset_count: got %h want %h", obs, exp); end
    #2 rst = 1'b1;
    #1;
    obs = {bus.count_out, bus.rollover_flag, bus.zero_flag, bus.wrap_pulse};
    total++;
    if (obs !== 11'd0) begin bad++; $display("FAIL async_reset: got %h want %h", obs, 11'd0); end
    tick();
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      obs = {bus.count_out, bus.rollover_flag, bus.zero_flag, bus.wrap_pulse};
      exp = {ec[i], 1'b0, ec[i] == 8'd0, 1'b0};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL post_reset[%0d]: got %h want %h", i, obs, exp); end
    end
    bus.count_enable = 0;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_prescale();
    test_down();
    test_saturate();
    test_priority();
    test_rv_zero();
    test_all_ones();
    test_mode_change();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
